// File: rtl/vic_pkg.sv
// vic_pkg: shared constants for the VIC-II raster timing core.
//   - PAL (6569) and NTSC (6567) line/frame geometry, sync and display windows,
//     so instances can be parameterised from named constants.
//   - RASTER_W: raster counter width.
//   - BADLINE_FIRST / BADLINE_LAST: raster range in which badlines can occur.
//   - in_window(): half-open [start,end) decode used by all window flags.
package vic_pkg;

    localparam int RASTER_W = 9;

    // PAL 6569
    localparam int PAL_CYCLES_PER_LINE = 63;
    localparam int PAL_LINES_PER_FRAME = 312;
    localparam int PAL_HSYNC_START     = 58;
    localparam int PAL_HSYNC_END       = 62;
    localparam int PAL_VSYNC_START     = 300;
    localparam int PAL_VSYNC_END       = 303;
    localparam int PAL_HDISP_START     = 12;
    localparam int PAL_HDISP_END       = 52;
    localparam int PAL_VDISP_START     = 16;
    localparam int PAL_VDISP_END       = 300;

    // NTSC 6567
    localparam int NTSC_CYCLES_PER_LINE = 65;
    localparam int NTSC_LINES_PER_FRAME = 263;
    localparam int NTSC_HSYNC_START     = 60;
    localparam int NTSC_HSYNC_END       = 64;
    localparam int NTSC_VSYNC_START     = 14;
    localparam int NTSC_VSYNC_END       = 17;
    localparam int NTSC_HDISP_START     = 12;
    localparam int NTSC_HDISP_END       = 52;
    localparam int NTSC_VDISP_START     = 40;
    localparam int NTSC_VDISP_END       = 250;

    // Badline window (inclusive on both ends)
    localparam logic [RASTER_W-1:0] BADLINE_FIRST = 9'h030;
    localparam logic [RASTER_W-1:0] BADLINE_LAST  = 9'h0F7;

    // Half-open window decode; start==end yields an empty window.
    function automatic logic in_window(input int value, input int win_start, input int win_end);
        return (value >= win_start) && (value < win_end);
    endfunction

endpackage

// File: rtl/vic_raster_irq.sv
// vic_raster_irq: raster-compare interrupt.
//   clk, reset      dot clock, asynchronous active-high reset
//   i_line_start    high on the clk where the counters enter dot 0, cycle 0
//   i_raster_next   raster line being entered on that clk
//   i_irq_line      compare value; values >= LINES_PER_FRAME never match
//   i_irq_en        gates only the output; pending latches regardless
//   i_irq_ack       clears pending (a simultaneous match wins)
//   o_irq           pending & i_irq_en
module vic_raster_irq
    import vic_pkg::*;
#(
    parameter int LINES_PER_FRAME = PAL_LINES_PER_FRAME
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_line_start,
    input  logic [RASTER_W-1:0] i_raster_next,
    input  logic [RASTER_W-1:0] i_irq_line,
    input  logic                i_irq_en,
    input  logic                i_irq_ack,
    output logic                o_irq
);

    logic match;
    logic pending_q, pending_d;

    always_comb begin
        match = i_line_start
             && (i_raster_next == i_irq_line)
             && (int'(i_irq_line) < LINES_PER_FRAME);
        pending_d = pending_q;
        if (match) begin
            pending_d = 1'b1;
        end else if (i_irq_ack) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Enable is applied combinationally so a late enable exposes a
    // pending interrupt on the same clk.
    assign o_irq = pending_q & i_irq_en;

endmodule

// File: rtl/vic_raster_timing.sv
// vic_raster_timing: VIC-II raster-beam timing core (PAL/NTSC by parameter).
// Keeps dot/cycle/raster counters on the dot clock and derives phi0, sync,
// display window, raster interrupt and (optionally) the badline flag.
//   clk, reset        dot clock; asynchronous active-high reset
//   o_phi0            CPU clock, low for the first half of each cycle
//   o_cycle_start     one-clk pulse on dot 0 of every cycle
//   o_cycle/o_raster  current cycle in line / current raster line
//   o_hsync/o_vsync   active-high sync
//   o_display_on      inside both display windows
//   i_irq_line/_en/_ack, o_irq   raster-compare interrupt
//   i_den, i_yscroll, o_badline  badline detection
// Optional feature macro: VIC_BADLINE_EN. Without it o_badline is tied low
// and i_den/i_yscroll are ignored.
// All flags are registered from next-state counter values, so each flag is
// aligned with the o_cycle/o_raster value it describes.
module vic_raster_timing
    import vic_pkg::*;
#(
    parameter int DOTS_PER_CYCLE  = 8,
    parameter int CYCLES_PER_LINE = PAL_CYCLES_PER_LINE,
    parameter int LINES_PER_FRAME = PAL_LINES_PER_FRAME,
    parameter int HSYNC_START     = PAL_HSYNC_START,
    parameter int HSYNC_END       = PAL_HSYNC_END,
    parameter int VSYNC_START     = PAL_VSYNC_START,
    parameter int VSYNC_END       = PAL_VSYNC_END,
    parameter int HDISP_START     = PAL_HDISP_START,
    parameter int HDISP_END       = PAL_HDISP_END,
    parameter int VDISP_START     = PAL_VDISP_START,
    parameter int VDISP_END       = PAL_VDISP_END
) (
    input  logic                               clk,
    input  logic                               reset,
    output logic                               o_phi0,
    output logic                               o_cycle_start,
    output logic [$clog2(CYCLES_PER_LINE)-1:0] o_cycle,
    output logic [RASTER_W-1:0]                o_raster,
    output logic                               o_hsync,
    output logic                               o_vsync,
    output logic                               o_display_on,
    input  logic [RASTER_W-1:0]                i_irq_line,
    input  logic                               i_irq_en,
    input  logic                               i_irq_ack,
    output logic                               o_irq,
    input  logic                               i_den,
    input  logic [2:0]                         i_yscroll,
    output logic                               o_badline
);

    localparam int DOT_W = $clog2(DOTS_PER_CYCLE);
    localparam int CYC_W = $clog2(CYCLES_PER_LINE);

    logic [DOT_W-1:0]    dot_q, dot_d;
    logic [CYC_W-1:0]    cycle_q, cycle_d;
    logic [RASTER_W-1:0] raster_q, raster_d;
    logic                dot_wrap, line_wrap;

    logic phi0_q, phi0_d;
    logic cycle_start_q, cycle_start_d;
    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic display_on_q, display_on_d;

    always_comb begin
        dot_wrap  = (dot_q == DOT_W'(DOTS_PER_CYCLE - 1));
        line_wrap = dot_wrap && (cycle_q == CYC_W'(CYCLES_PER_LINE - 1));

        dot_d = dot_wrap ? '0 : dot_q + 1'b1;

        cycle_d = cycle_q;
        if (dot_wrap) begin
            cycle_d = line_wrap ? '0 : cycle_q + 1'b1;
        end

        raster_d = raster_q;
        if (line_wrap) begin
            raster_d = (raster_q == RASTER_W'(LINES_PER_FRAME - 1)) ? '0 : raster_q + 1'b1;
        end

        // Decode from next-state values so the registered flags line up
        // with the registered counters.
        phi0_d        = (int'(dot_d) >= DOTS_PER_CYCLE / 2);
        cycle_start_d = dot_wrap;
        hsync_d       = in_window(int'(cycle_d), HSYNC_START, HSYNC_END);
        vsync_d       = in_window(int'(raster_d), VSYNC_START, VSYNC_END);
        display_on_d  = in_window(int'(cycle_d), HDISP_START, HDISP_END)
                     && in_window(int'(raster_d), VDISP_START, VDISP_END);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dot_q         <= '0;
            cycle_q       <= '0;
            raster_q      <= '0;
            phi0_q        <= 1'b0;
            cycle_start_q <= 1'b1;  // reset state is dot 0 of cycle 0
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            display_on_q  <= 1'b0;
        end else begin
            dot_q         <= dot_d;
            cycle_q       <= cycle_d;
            raster_q      <= raster_d;
            phi0_q        <= phi0_d;
            cycle_start_q <= cycle_start_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            display_on_q  <= display_on_d;
        end
    end

    assign o_phi0        = phi0_q;
    assign o_cycle_start = cycle_start_q;
    assign o_cycle       = cycle_q;
    assign o_raster      = raster_q;
    assign o_hsync       = hsync_q;
    assign o_vsync       = vsync_q;
    assign o_display_on  = display_on_q;

    // A line wrap is exactly the clk that enters dot 0, cycle 0; leaving
    // reset is not a clock edge, so it never produces a match.
    vic_raster_irq #(
        .LINES_PER_FRAME(LINES_PER_FRAME)
    ) u_irq (
        .clk          (clk),
        .reset        (reset),
        .i_line_start (line_wrap),
        .i_raster_next(raster_d),
        .i_irq_line   (i_irq_line),
        .i_irq_en     (i_irq_en),
        .i_irq_ack    (i_irq_ack),
        .o_irq        (o_irq)
    );

`ifdef VIC_BADLINE_EN
    logic den_latch_q, den_latch_d;
    logic badline_q, badline_d;

    always_comb begin
        den_latch_d = den_latch_q;
        if (raster_d == '0) begin
            den_latch_d = 1'b0;
        end else if ((raster_d == BADLINE_FIRST) && i_den) begin
            den_latch_d = 1'b1;
        end
        badline_d = den_latch_d
                 && (raster_d >= BADLINE_FIRST)
                 && (raster_d <= BADLINE_LAST)
                 && (raster_d[2:0] == i_yscroll);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            den_latch_q <= 1'b0;
            badline_q   <= 1'b0;
        end else begin
            den_latch_q <= den_latch_d;
            badline_q   <= badline_d;
        end
    end

    assign o_badline = badline_q;
`else
    logic unused_badline_inputs;
    assign unused_badline_inputs = ^{i_den, i_yscroll};
    assign o_badline = 1'b0;
`endif

endmodule
